// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of the CPU data-memory bus. Replaces a bare RAM beside the CPU
// and adds a small MMIO window at 0xFF00..0xFFFF.
//
// Address map (16-bit word addresses):
//   0x0000 .. 2^RAM_AW-1  word RAM, asynchronous read, written at the clock edge
//   0xFF00  TXDATA  write: push mem_in into the TX FIFO;  read: 0
//   0xFF01  STATUS  read : {drop_cnt[7:0], count[3:0], 2'b00, full, empty}
//                   write: clears the drop counter (data ignored)
//   0xFF02  CYCLE   read : free-running 16-bit cycle counter
//                   write: loads mem_in (takes priority over the increment)
//   other 0xFFxx offsets and every other address: read 0, writes ignored
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset (RAM contents are not reset)
//   mem_we    CPU write strobe, committed at the rising edge
//   mem_addr  CPU word address
//   mem_in    CPU write data
//   mem_out   read data, combinational from mem_addr and pre-edge state
//   tx_valid  TX FIFO non-empty
//   tx_data   FIFO head word (0 when empty)
//   tx_ready  downstream accepts the head word this cycle
//
// TX stream handshake: a word transfers at a rising edge where tx_valid and
// tx_ready are both high. tx_valid never depends on tx_ready, and tx_data is
// held stable while tx_valid is high and no transfer has occurred.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int RAM_AW     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_in,
  output logic [15:0] mem_out,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready
);

  // FIFO_DEPTH is a power of two, so pointers wrap naturally at PW bits.
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C = 4'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [7:0] OFS_TXDATA = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h01;
  localparam logic [7:0] OFS_CYCLE  = 8'h02;

  // ---------------------------------------------------------------------------
  // Address decode. MMIO is checked first so that it always wins, even for a
  // RAM_AW wide enough to reach the top page.
  // ---------------------------------------------------------------------------
  logic sel_mmio;
  logic sel_ram;
  logic [RAM_AW-1:0] ram_idx;

  assign sel_mmio = (mem_addr[15:8] == 8'hFF);
  assign sel_ram  = !sel_mmio && ((mem_addr >> RAM_AW) == 16'd0);
  assign ram_idx  = mem_addr[RAM_AW-1:0];

  logic wr_txdata;
  logic wr_status;
  logic wr_cycle;

  assign wr_txdata = mem_we && sel_mmio && (mem_addr[7:0] == OFS_TXDATA);
  assign wr_status = mem_we && sel_mmio && (mem_addr[7:0] == OFS_STATUS);
  assign wr_cycle  = mem_we && sel_mmio && (mem_addr[7:0] == OFS_CYCLE);

  // ---------------------------------------------------------------------------
  // RAM: no reset, write at the edge, asynchronous read.
  // ---------------------------------------------------------------------------
  logic [15:0] ram [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (mem_we && sel_ram) begin
      ram[ram_idx] <= mem_in;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [3:0]    count;
  logic [7:0]    drop_cnt;
  logic [15:0]   cycle_cnt;

  logic empty;
  logic full;
  logic pop;
  logic push_ok;
  logic push_drop;

  assign empty = (count == 4'd0);
  assign full  = (count == DEPTH_C);
  assign pop   = !empty && tx_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still
  // succeeds when the head is leaving.
  assign push_ok   = wr_txdata && (!full || pop);
  assign push_drop = wr_txdata && full && !pop;

  assign tx_valid = !empty;
  assign tx_data  = empty ? 16'h0000 : fifo_mem[rd_ptr];

  // Storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= mem_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter: saturates at 0xFF; a STATUS write clears it and wins over a
  // drop in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'h00;
    end else if (wr_status) begin
      drop_cnt <= 8'h00;
    end else if (push_drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running cycle counter; a CPU write loads it instead of incrementing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= 16'h0000;
    end else if (wr_cycle) begin
      cycle_cnt <= mem_in;
    end else begin
      cycle_cnt <= cycle_cnt + 16'h0001;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: purely combinational, no side effects, pre-edge state.
  // ---------------------------------------------------------------------------
  logic [15:0] status_word;

  assign status_word = {drop_cnt, count, 2'b00, full, empty};

  always_comb begin
    mem_out = 16'h0000;
    if (sel_mmio) begin
      case (mem_addr[7:0])
        OFS_STATUS: mem_out = status_word;
        OFS_CYCLE:  mem_out = cycle_cnt;
        default:    mem_out = 16'h0000;
      endcase
    end else if (sel_ram) begin
      mem_out = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] mem_in = 16'h0000;
  logic [15:0] mem_out;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.RAM_AW(12), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_out  (mem_out),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Compare every word leaving the FIFO against the expected queue.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL tx_extra: got %h expected no word", tx_data);
      end else begin
        check("tx_order", tx_data, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    mem_we = 1'b1; mem_addr = addr; mem_in = data;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic push_tx(input logic [15:0] data, input bit expect_accept);
    if (expect_accept) exp_q.push_back(data);
    wr(16'hFF00, data);
  endtask

  task automatic rd_check(input string name, input logic [15:0] addr, input logic [15:0] exp);
    mem_we = 1'b0; mem_addr = addr;
    @(negedge clk);
    check(name, mem_out, exp);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] din;
    logic        chk;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{1'b1, 16'h0010, 16'h1111, 1'b0, 16'h0000, "ram_wr1"});
    vecs.push_back('{1'b1, 16'h0010, 16'h1234, 1'b1, 16'h1111, "ram_same_cycle_old"});
    vecs.push_back('{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, "ram_rd"});
    vecs.push_back('{1'b1, 16'h0000, 16'h5A5A, 1'b0, 16'h0000, "ram_wr0"});
    vecs.push_back('{1'b1, 16'h2000, 16'hDEAD, 1'b1, 16'h0000, "unmapped_2000_wr"});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, "no_alias_2000"});
    vecs.push_back('{1'b1, 16'h1000, 16'h7777, 1'b1, 16'h0000, "unmapped_1000_wr"});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, "no_alias_1000"});
    vecs.push_back('{1'b1, 16'h0FFF, 16'hBEEF, 1'b0, 16'h0000, "ram_wr_top"});
    vecs.push_back('{1'b0, 16'h0FFF, 16'h0000, 1'b1, 16'hBEEF, "ram_rd_top"});
    vecs.push_back('{1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000, "unmapped_rd"});
    vecs.push_back('{1'b1, 16'hFF10, 16'h4321, 1'b1, 16'h0000, "mmio_hole"});
    vecs.push_back('{1'b0, 16'hFF00, 16'h0000, 1'b1, 16'h0000, "txdata_rd_zero"});
    vecs.push_back('{1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h0001, "status_after_hole"});

    // Reset state
    repeat (3) tick();
    mem_addr = 16'hFF01;
    @(negedge clk);
    check("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    check("rst_tx_data", tx_data, 16'h0000);
    check("rst_status", mem_out, 16'h0001);
    tick();
    rst_n = 1'b1;
    mem_addr = 16'hFF02;
    @(negedge clk);
    check("cycle_start", mem_out, 16'h0000);
    tick();

    // Table-driven bus accesses
    for (int i = 0; i < vecs.size(); i++) begin
      mem_we = vecs[i].we; mem_addr = vecs[i].addr; mem_in = vecs[i].din;
      @(negedge clk);
      if (vecs[i].chk) check(vecs[i].name, mem_out, vecs[i].exp);
      tick();
    end
    mem_we = 1'b0;

    // Overflow: five pushes, fifth dropped. Head not visible during first push.
    tx_ready = 1'b0;
    exp_q.push_back(16'h00A1);
    mem_we = 1'b1; mem_addr = 16'hFF00; mem_in = 16'h00A1;
    @(negedge clk);
    check("head_not_early", {15'd0, tx_valid}, 16'h0000);
    tick();
    mem_we = 1'b0;
    push_tx(16'h00A2, 1'b1);
    push_tx(16'h00A3, 1'b1);
    push_tx(16'h00A4, 1'b1);
    push_tx(16'h00A5, 1'b0);
    @(negedge clk);
    check("head_a1", tx_data, 16'h00A1);
    rd_check("status_full_drop", 16'hFF01, 16'h0142);
    tx_ready = 1'b1;
    repeat (4) tick();
    rd_check("status_drained", 16'hFF01, 16'h0101);
    check("drained_valid", {15'd0, tx_valid}, 16'h0000);

    // Full FIFO, pop and push in the same cycle
    tx_ready = 1'b0;
    push_tx(16'h00C1, 1'b1);
    push_tx(16'h00C2, 1'b1);
    push_tx(16'h00C3, 1'b1);
    push_tx(16'h00C4, 1'b1);
    tx_ready = 1'b1;
    push_tx(16'h00B0, 1'b1);
    tx_ready = 1'b0;
    rd_check("status_full_no_drop", 16'hFF01, 16'h0142);
    tx_ready = 1'b1;
    repeat (4) tick();
    tx_ready = 1'b0;
    rd_check("status_empty_again", 16'hFF01, 16'h0101);

    // Drop counter clear
    wr(16'hFF01, 16'h5555);
    rd_check("status_cleared", 16'hFF01, 16'h0001);

    // Cycle counter load and wrap
    wr(16'hFF02, 16'hFFFE);
    rd_check("cycle_load", 16'hFF02, 16'hFFFE);
    rd_check("cycle_ffff", 16'hFF02, 16'hFFFF);
    rd_check("cycle_wrap", 16'hFF02, 16'h0000);

    // Asynchronous reset mid-drain with three words still queued
    push_tx(16'h00D1, 1'b1);
    push_tx(16'h00D2, 1'b0);
    push_tx(16'h00D3, 1'b0);
    push_tx(16'h00D4, 1'b0);
    tx_ready = 1'b1;
    mem_addr = 16'hFF01;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {15'd0, tx_valid}, 16'h0000);
    check("async_rst_data", tx_data, 16'h0000);
    tx_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mem_addr = 16'hFF02;
    @(negedge clk);
    check("post_rst_cycle0", mem_out, 16'h0000);
    tick();
    rd_check("post_rst_cycle1", 16'hFF02, 16'h0001);
    rd_check("post_rst_status", 16'hFF01, 16'h0001);
    tx_ready = 1'b1;
    repeat (2) tick();
    check("post_rst_no_tx", {15'd0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    check("exp_q_empty", 16'(exp_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory bus: services the CPU's `mem_we`/`mem_addr`/`mem_in` requests and returns `mem_out`.
- Contains a word-addressed RAM and a small MMIO window.
- The MMIO window provides a transmit FIFO drained over a valid/ready stream, a status register, and a free-running cycle counter.
- Sits beside the CPU at top level, replacing a bare RAM.

Parameters:
- RAM_AW, 12, RAM address width; RAM occupies 0x0000..(2^RAM_AW - 1), 16-bit words.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_we  in  1  CPU write strobe; write committed at the rising edge.
- mem_addr  in  16  CPU word address.
- mem_in  in  16  CPU write data.
- mem_out  out  16  read data to CPU; combinational from mem_addr and current state.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  16  FIFO head word.
- tx_ready  in  1  downstream accepts head this cycle.

Behaviour:
- Interface: one clock (`clk`); reset `rst_n` is asynchronous and active-low.

Reset (async assert, sync release):
- FIFO empty; tx_valid=0; tx_data=0.
- Drop counter=0; cycle counter=0.
- RAM contents are not reset.
- Reset mid-operation flushes the FIFO; any pending word is lost.

Address decode:
- addr[15:8]==8'hFF selects MMIO.
- addr[15:RAM_AW]==0 selects RAM.
- Anything else is unmapped: reads return 0, writes are ignored.

Reads:
- Zero wait states; mem_out is combinational.
- Reads reflect pre-edge state, so a same-cycle write is not visible until the next cycle.
- Reads have no side effects.

RAM:
- Write at the edge when mem_we=1.
- Read is asynchronous: mem_out = ram[addr[RAM_AW-1:0]].

MMIO registers (other 0xFFxx offsets read 0 and ignore writes):
- 0xFF00 TXDATA:
  - Write pushes mem_in into the FIFO.
  - Read returns 0.
- 0xFF01 STATUS (read):
  - bit0 = empty.
  - bit1 = full.
  - bits[7:4] = occupancy count (0..FIFO_DEPTH).
  - bits[15:8] = drop counter.
  - bits[3:2] = 0.
- 0xFF01 STATUS (write): any write clears the drop counter.
- 0xFF02 CYCLE:
  - Read returns the 16-bit counter, which increments every cycle and wraps 0xFFFF->0x0000.
  - Write loads mem_in; the write wins over the increment.
  - The value read on the next cycle after a write is mem_in.

FIFO:
- tx_valid = !empty; tx_data = head word, or 0 when empty.
- Pop occurs at the edge when tx_valid && tx_ready.
- Push when not full: accepted; occupancy increments.
- Push and pop in the same cycle: both happen; occupancy unchanged. This holds even when full, since the pop frees the slot.
- Push when full with no pop: word dropped; drop counter increments, saturating at 0xFF.
- Drop-counter clear coinciding with a drop: the clear wins (result 0).
- tx_ready while empty: no effect.
- Pointers wrap modulo FIFO_DEPTH.
- Pushed data appears at the head at the earliest on the cycle after the push.
- FIFO ordering is strict.

Test Plan:
- Reset, then write 0x1234 to 0x0010, then read 0x0010 -> mem_out=0x1234. Read 0x2000 -> 0. Write to 0x2000 does not alias into RAM (0x0000 unchanged).
- tx_ready=0; push 0xA1..0xA5 (5 writes to 0xFF00) -> STATUS reads 0x0142 (full, count 4, drop 1). Raise tx_ready -> tx_data sequence 0xA1,0xA2,0xA3,0xA4, then tx_valid=0 and STATUS=0x0101.
- FIFO full, tx_ready=1, push 0xB0 the same cycle -> no drop, count stays 4, 0xB0 emerges last.
- Write 0xFFFE to 0xFF02 -> reads 0xFFFE, 0xFFFF, 0x0000 on consecutive cycles. A write to 0xFF01 clears the drop count to 0.
- Assert rst_n=0 asynchronously with 3 words queued mid-drain -> tx_valid drops immediately. After release, STATUS=0x0001 and CYCLE counts from 0.
